reg_scoreboard: RTL

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

---
 rtl/reg_scoreboard.sv | 68 ++++++
 1 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending-write counters with issue stall, flush and sticky error.
// Optional macro SB_RET_BYPASS_EN forwards a same-cycle last retire to clear source hazards.
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_vld,
  input  logic [4:0]      iss_rs1_ind,
  input  logic [4:0]      iss_rs2_ind,
  input  logic            iss_rs1_use,
  input  logic            iss_rs2_use,
  input  logic [4:0]      iss_rd_ind,
  input  logic            iss_rd_wr,
  input  logic            ret_vld,
  input  logic [4:0]      ret_rd_ind,
  input  logic            flush,
  output logic            stall,
  output logic [NREG-1:0] busy,
  output logic            err
);
  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state;
  logic [CNT_W-1:0] cnt [NREG];
  logic [CNT_W-1:0] c1, c2, cd;
  logic byp1, byp2, hazard, acc, ret;
  function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] idx);
    return (32'(idx) < NREG) ? cnt[idx] : '0;
  endfunction
  assign c1 = cnt_of(iss_rs1_ind);
  assign c2 = cnt_of(iss_rs2_ind);
  assign cd = cnt_of(iss_rd_ind);
`ifdef SB_RET_BYPASS_EN
  assign byp1 = ret_vld && ret_rd_ind == iss_rs1_ind && c1 == CNT_W'(1);
  assign byp2 = ret_vld && ret_rd_ind == iss_rs2_ind && c2 == CNT_W'(1);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif
  always_comb begin
    hazard = iss_vld && ((iss_rs1_use && c1 != '0 && !byp1) ||
                         (iss_rs2_use && c2 != '0 && !byp2) ||
                         (iss_rd_wr && cd == MAX));
    stall  = hazard || state != RUN;
    acc    = iss_vld && !stall && iss_rd_wr && iss_rd_ind != 5'd0 && !flush;
    ret    = ret_vld && ret_rd_ind != 5'd0 && state == RUN && !flush;
    for (int i = 0; i < NREG; i++) busy[i] = cnt[i] != '0;
  end
  // a same-index issue and retire in one cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      err   <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt[i] <= '0;
    end else begin
      state <= flush ? FLUSH : RUN;
      if (ret && cnt_of(ret_rd_ind) == '0) err <= 1'b1;
      cnt[0] <= '0;
      for (int i = 1; i < NREG; i++)
        cnt[i] <= (flush || state == FLUSH) ? '0 :
                  (acc && iss_rd_ind == 5'(i) && ret && ret_rd_ind == 5'(i)) ? cnt[i] :
                  (acc && iss_rd_ind == 5'(i)) ? cnt[i] + CNT_W'(1) :
                  (ret && ret_rd_ind == 5'(i) && cnt[i] != '0) ? cnt[i] - CNT_W'(1) : cnt[i];
    end
  end
endmodule
